reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular reorder buffer (ROB) for the out-of-order core, between dispatch/issue and commit.
//  Allocates tags in program order and captures results from the CDB.
//  Forwards store data and exposes the head entry for in-order commit.
//  Answers load/older-store conflict queries and random-access value reads.
// PARAMETERS
//  ROB_SIZE  4  number of entries; tags are 0..ROB_SIZE-1; `ROB_TAG_LEN >= $clog2(ROB_SIZE)
// PORTS
//  clock                 in   1            system clock
//  reset                 in   1            synchronous, active-high
//  alloc_enable          in   1            allocate tail entry this cycle
//  alloc_wr_mem          in   1            new instruction is a store
//  alloc_value_in        in   XLEN         store data, when alloc_value_in_valid
//  alloc_store_dep       in   ROB_TAG_LEN  tag producing store data, when !alloc_value_in_valid
//  alloc_value_in_valid  in   1            store data already available at allocation
//  dest_reg              in   5            architectural destination register
//  cdb_data              in   CDB_DATA     {valid, rob_tag, value} broadcast
//  read_rob_tag          in   ROB_TAG_LEN  entry to read
//  load_address          in   XLEN         load address for the conflict check
//  load_rob_tag          in   ROB_TAG_LEN  tag of the querying load
//  full                  out  1            count == ROB_SIZE
//  alloc_slot            out  ROB_TAG_LEN  tag the next allocation receives (tail)
//  read_value            out  XLEN         ROB[read_rob_tag].value, combinational
//  pending_stores        out  1            older store may alias the load
//  head_entry            out  ROB_ENTRY    entry at head pointer; shown even if invalid
//  head_ready            out  1            head entry may commit
// BEHAVIOUR
//  - Reset: all entries cleared to zero (valid=0); head=tail=count=0; full=0, alloc_slot=0, head_ready=0.
//  - head_ready = valid & (wr_mem ? (addr_ready & value_ready) : value_ready); combinational from state.
//  - Commit: on a posedge with head_ready=1, the head entry is invalidated and head advances.
//    No external acknowledge.
//  - Alloc: on a posedge with alloc_enable & (!full | head_ready), write at tail and advance tail.
//    The written entry gets valid=1, wr_mem, dest_reg, value_ready=0 and addr_ready=0.
//    alloc_enable while full and head not ready is ignored.
//  - Commit and alloc in the same cycle are both allowed, including when full; count is unchanged.
//  - Store data at alloc: if alloc_value_in_valid, value=alloc_value_in and value_ready=1.
//    Otherwise store_dep is recorded. If the same-cycle CDB is valid with rob_tag==alloc_store_dep,
//    value is captured at alloc.
//    The issue stage supplies data for dependencies that already completed.
//  - CDB (registered, next cycle visible), for the entry E = cdb.rob_tag:
//    - non-store E: value=cdb.value, value_ready=1.
//    - store E: dest_addr=cdb.value, addr_ready=1.
//    - every valid store with !value_ready and store_dep==cdb.rob_tag: value=cdb.value, value_ready=1.
//  - Pointers wrap modulo ROB_SIZE. Values are XLEN wide, with no arithmetic beyond the pointer increments.
//  - pending_stores: scan entries from head up to (excluding) load_rob_tag, wrap-aware.
//    It is 1 if any valid store in that range matches per CONFIGURATION.
//  - Reset mid-operation discards all entries in-flight.
// CONFIGURATION
//  ROB_ADDR_DISAMBIG_EN defined: an older store matches only if !addr_ready or dest_addr==load_address.
//  ROB_ADDR_DISAMBIG_EN undefined: any older valid store matches (conservative).
// STRUCTURE
//  Shared package: XLEN, ROB_TAG_LEN, ZERO_REG, TRUE/FALSE, CDB_DATA {valid,rob_tag,value}.
//  Shared package: ROB_ENTRY {valid,wr_mem,dest_reg,dest_addr,value,value_ready,addr_ready,store_dep}.
//  Sub-module rob_store_scan: combinational age-ordered pending-store search.
// TESTING
//  1 alloc dest3 -> alloc_slot=1, head dest=3, not ready.
//    Then CDB{1,0,5} -> head_ready=1, value=5, and the head commits on the following edge.
//  2 alloc tags1,2; CDB{1,2,11}, read_rob_tag=2 -> read_value=11, head_ready=0.
//    Then CDB{1,1,5} -> tag1 commits (5), then tag2 commits (11), then head valid=0, head_ready=0.
//  3 ROB_SIZE allocs -> full=0 during the allocs, then 1.
//    Ready the head with alloc_enable held -> commit+alloc in one edge; full stays 1, head dest=2.
//  4 store with value_in 10, CDB{1,tag,11} -> head_ready=1, dest_addr=11, value=10.
//  5 store deps on tag T; CDB{1,T,5} in the same cycle as a second store dep T is allocated.
//    Both stores get value_ready=1.
//    A store becomes ready only after its own CDB address (2).
//  6 older store addr 0x40; load 0x40 -> pending_stores=1.
//    Load 0x80 -> 0 with ROB_ADDR_DISAMBIG_EN defined, 1 without.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: CDB broadcast, ROB entry, tag helpers.
// Optional feature macro: ROB_ADDR_DISAMBIG_EN (see rob_store_scan).
package reorder_buffer_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_SIZE    = 4;
    localparam int ROB_TAG_LEN = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic       TRUE     = 1'b1;
    localparam logic       FALSE    = 1'b0;

    typedef logic [ROB_TAG_LEN-1:0] rob_tag_t;

    typedef struct packed {
        logic            valid;
        rob_tag_t        rob_tag;
        logic [XLEN-1:0] value;
    } cdb_data_t;

    typedef struct packed {
        logic            valid;
        logic            wr_mem;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] dest_addr;
        logic [XLEN-1:0] value;
        logic            value_ready;
        logic            addr_ready;
        rob_tag_t        store_dep;
    } rob_entry_t;

    // Explicit wrap so a non-power-of-two ROB_SIZE still cycles correctly.
    function automatic rob_tag_t tag_inc(input rob_tag_t t);
        return (t == rob_tag_t'(ROB_SIZE - 1)) ? '0 : rob_tag_t'(t + 1'b1);
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch/CDB/commit-side signal bundle of the reorder buffer.
// master = core side driving requests, slave = the ROB itself.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic            alloc_enable;
    logic            alloc_wr_mem;
    logic [XLEN-1:0] alloc_value_in;
    rob_tag_t        alloc_store_dep;
    logic            alloc_value_in_valid;
    logic [4:0]      dest_reg;
    cdb_data_t       cdb_data;
    rob_tag_t        read_rob_tag;
    logic [XLEN-1:0] load_address;
    rob_tag_t        load_rob_tag;

    logic            full;
    rob_tag_t        alloc_slot;
    logic [XLEN-1:0] read_value;
    logic            pending_stores;
    rob_entry_t      head_entry;
    logic            head_ready;

    modport master (
        output alloc_enable, alloc_wr_mem, alloc_value_in, alloc_store_dep,
               alloc_value_in_valid, dest_reg, cdb_data, read_rob_tag,
               load_address, load_rob_tag,
        input  full, alloc_slot, read_value, pending_stores, head_entry, head_ready
    );

    modport slave (
        input  alloc_enable, alloc_wr_mem, alloc_value_in, alloc_store_dep,
               alloc_value_in_valid, dest_reg, cdb_data, read_rob_tag,
               load_address, load_rob_tag,
        output full, alloc_slot, read_value, pending_stores, head_entry, head_ready
    );
endinterface

// File: rtl/reorder_buffer_store_scan.sv
// Age-ordered search for stores older than a load, walking from head up to the load's tag.
// ROB_ADDR_DISAMBIG_EN: ignore older stores whose known address differs from the load's.
module rob_store_scan
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_SIZE-1:0] store_v_i,
    input  logic [ROB_SIZE-1:0] addr_rdy_i,
    input  logic [XLEN-1:0]     dest_addr_i [ROB_SIZE],
    input  rob_tag_t            head_i,
    input  rob_tag_t            load_tag_i,
    input  logic [XLEN-1:0]     load_addr_i,
    output logic                pending_o
);
    logic [ROB_SIZE-1:0] match;

`ifdef ROB_ADDR_DISAMBIG_EN
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            match[i] = !addr_rdy_i[i] || (dest_addr_i[i] == load_addr_i);
        end
    end
`else
    logic unused_addr_info;
    assign match            = '1;
    assign unused_addr_info = ^{addr_rdy_i, load_addr_i, dest_addr_i[0], dest_addr_i[1],
                                dest_addr_i[2], dest_addr_i[3]};
`endif

    rob_tag_t idx;
    logic     in_range;

    always_comb begin
        pending_o = FALSE;
        in_range  = TRUE;
        idx       = head_i;
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (idx == load_tag_i) in_range = FALSE;
            if (in_range && store_v_i[idx] && match[idx]) pending_o = TRUE;
            idx = tag_inc(idx);
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, CDB capture, store data forwarding, in-order commit.
// Build option ROB_ADDR_DISAMBIG_EN refines the pending-store query (see rob_store_scan).
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    reorder_buffer_if.slave  bus
);
    rob_entry_t                entries_q [ROB_SIZE];
    rob_entry_t                entries_d [ROB_SIZE];
    rob_tag_t                  head_q, head_d, tail_q, tail_d;
    logic [ROB_TAG_LEN:0]      count_q, count_d;

    cdb_data_t  cdb;
    rob_entry_t head_e;
    logic       full, head_ready, alloc_fire;

    assign cdb        = bus.cdb_data;
    assign head_e     = entries_q[head_q];
    assign full       = (count_q == (ROB_TAG_LEN + 1)'(ROB_SIZE));
    assign head_ready = head_e.valid &
                        (head_e.wr_mem ? (head_e.addr_ready & head_e.value_ready) : head_e.value_ready);
    // A full ROB can still accept when the head retires on the same edge.
    assign alloc_fire = bus.alloc_enable & (!full | head_ready);

    assign bus.full       = full;
    assign bus.alloc_slot = tail_q;
    assign bus.read_value = entries_q[bus.read_rob_tag].value;
    assign bus.head_entry = head_e;
    assign bus.head_ready = head_ready;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (head_ready) begin
            entries_d[head_q].valid = FALSE;
            head_d                  = tag_inc(head_q);
        end

        if (cdb.valid) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (entries_q[i].valid && entries_q[i].wr_mem && !entries_q[i].value_ready &&
                    entries_q[i].store_dep == cdb.rob_tag) begin
                    entries_d[i].value       = cdb.value;
                    entries_d[i].value_ready = TRUE;
                end
            end
            // For a store the broadcast result is its address, otherwise its value.
            if (entries_q[cdb.rob_tag].wr_mem) begin
                entries_d[cdb.rob_tag].dest_addr  = cdb.value;
                entries_d[cdb.rob_tag].addr_ready = TRUE;
            end else begin
                entries_d[cdb.rob_tag].value       = cdb.value;
                entries_d[cdb.rob_tag].value_ready = TRUE;
            end
        end

        // Allocation last: when full it reuses the slot the head just vacated.
        if (alloc_fire) begin
            entries_d[tail_q]           = '0;
            entries_d[tail_q].valid     = TRUE;
            entries_d[tail_q].wr_mem    = bus.alloc_wr_mem;
            entries_d[tail_q].dest_reg  = bus.dest_reg;
            entries_d[tail_q].store_dep = bus.alloc_store_dep;
            if (bus.alloc_wr_mem) begin
                if (bus.alloc_value_in_valid) begin
                    entries_d[tail_q].value       = bus.alloc_value_in;
                    entries_d[tail_q].value_ready = TRUE;
                end else if (cdb.valid && cdb.rob_tag == bus.alloc_store_dep) begin
                    entries_d[tail_q].value       = cdb.value;
                    entries_d[tail_q].value_ready = TRUE;
                end
            end
            tail_d = tag_inc(tail_q);
        end

        case ({alloc_fire, head_ready})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    logic [ROB_SIZE-1:0] store_v, addr_rdy;
    logic [XLEN-1:0]     dest_addr [ROB_SIZE];

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            store_v[i]   = entries_q[i].valid & entries_q[i].wr_mem;
            addr_rdy[i]  = entries_q[i].addr_ready;
            dest_addr[i] = entries_q[i].dest_addr;
        end
    end

    rob_store_scan u_scan (
        .store_v_i   (store_v),
        .addr_rdy_i  (addr_rdy),
        .dest_addr_i (dest_addr),
        .head_i      (head_q),
        .load_tag_i  (bus.load_rob_tag),
        .load_addr_i (bus.load_address),
        .pending_o   (bus.pending_stores)
    );
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expected values are hand-derived per step.
// Honors ROB_ADDR_DISAMBIG_EN for the pending-store expectation.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer_if bus_if ();

    reorder_buffer dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cdb(input logic v, input rob_tag_t t, input logic [31:0] val);
        bus_if.cdb_data = '{valid: v, rob_tag: t, value: val};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus_if.alloc_enable         = 1'b0;
        bus_if.alloc_wr_mem         = 1'b0;
        bus_if.alloc_value_in       = '0;
        bus_if.alloc_store_dep      = '0;
        bus_if.alloc_value_in_valid = 1'b0;
        bus_if.dest_reg             = '0;
        bus_if.read_rob_tag         = '0;
        bus_if.load_address         = '0;
        bus_if.load_rob_tag         = '0;
        set_cdb(1'b0, '0, '0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_full", 32'(bus_if.full), 0);
        check("rst_slot", 32'(bus_if.alloc_slot), 0);
        check("rst_ready", 32'(bus_if.head_ready), 0);
        check("rst_valid", 32'(bus_if.head_entry.valid), 0);

        // 1: single alloc, result via CDB, commit
        bus_if.alloc_enable = 1'b1;
        bus_if.dest_reg     = 5'd3;
        tick();
        bus_if.alloc_enable = 1'b0;
        #1;
        check("t1_slot", 32'(bus_if.alloc_slot), 1);
        check("t1_dest", 32'(bus_if.head_entry.dest_reg), 3);
        check("t1_notready", 32'(bus_if.head_ready), 0);
        set_cdb(1'b1, 2'd0, 32'd5);
        tick();
        set_cdb(1'b0, '0, '0);
        #1;
        check("t1_ready", 32'(bus_if.head_ready), 1);
        check("t1_value", bus_if.head_entry.value, 5);
        tick();
        check("t1_commit_valid", 32'(bus_if.head_entry.valid), 0);
        check("t1_commit_ready", 32'(bus_if.head_ready), 0);

        // 2: out-of-order completion, in-order commit
        bus_if.alloc_enable = 1'b1;
        bus_if.dest_reg     = 5'd4;
        tick();
        bus_if.dest_reg     = 5'd5;
        tick();
        bus_if.alloc_enable = 1'b0;
        check("t2_slot", 32'(bus_if.alloc_slot), 3);
        set_cdb(1'b1, 2'd2, 32'd11);
        tick();
        set_cdb(1'b0, '0, '0);
        bus_if.read_rob_tag = 2'd2;
        #1;
        check("t2_read", bus_if.read_value, 11);
        check("t2_head_wait", 32'(bus_if.head_ready), 0);
        set_cdb(1'b1, 2'd1, 32'd5);
        tick();
        set_cdb(1'b0, '0, '0);
        #1;
        check("t2_h1_ready", 32'(bus_if.head_ready), 1);
        check("t2_h1_value", bus_if.head_entry.value, 5);
        tick();
        check("t2_h2_ready", 32'(bus_if.head_ready), 1);
        check("t2_h2_value", bus_if.head_entry.value, 11);
        tick();
        check("t2_empty_valid", 32'(bus_if.head_entry.valid), 0);
        check("t2_empty_ready", 32'(bus_if.head_ready), 0);

        // 3: fill, reject while full, commit+alloc on one edge
        do_reset();
        bus_if.alloc_enable = 1'b1;
        for (int i = 0; i < ROB_SIZE; i++) begin
            bus_if.dest_reg = 5'(i + 1);
            #1;
            check("t3_fill_full", 32'(bus_if.full), 0);
            tick();
        end
        check("t3_full", 32'(bus_if.full), 1);
        bus_if.dest_reg = 5'd9;
        tick();
        check("t3_reject_slot", 32'(bus_if.alloc_slot), 0);
        check("t3_reject_dest", 32'(bus_if.head_entry.dest_reg), 1);
        set_cdb(1'b1, 2'd0, 32'd7);
        tick();
        set_cdb(1'b0, '0, '0);
        #1;
        check("t3_head_ready", 32'(bus_if.head_ready), 1);
        tick();
        bus_if.alloc_enable = 1'b0;
        bus_if.read_rob_tag = 2'd0;
        #1;
        check("t3_still_full", 32'(bus_if.full), 1);
        check("t3_new_head", 32'(bus_if.head_entry.dest_reg), 2);
        check("t3_slot", 32'(bus_if.alloc_slot), 1);
        check("t3_reused_value", bus_if.read_value, 0);

        // 4: store with data at allocation
        do_reset();
        bus_if.alloc_enable         = 1'b1;
        bus_if.alloc_wr_mem         = 1'b1;
        bus_if.alloc_value_in_valid = 1'b1;
        bus_if.alloc_value_in       = 32'd10;
        tick();
        bus_if.alloc_enable         = 1'b0;
        bus_if.alloc_value_in_valid = 1'b0;
        #1;
        check("t4_no_addr", 32'(bus_if.head_ready), 0);
        set_cdb(1'b1, 2'd0, 32'd11);
        tick();
        set_cdb(1'b0, '0, '0);
        #1;
        check("t4_ready", 32'(bus_if.head_ready), 1);
        check("t4_addr", bus_if.head_entry.dest_addr, 11);
        check("t4_value", bus_if.head_entry.value, 10);

        // 5: store data forwarding, including same-cycle capture at allocation
        do_reset();
        bus_if.alloc_enable    = 1'b1;
        bus_if.alloc_wr_mem    = 1'b0;
        bus_if.dest_reg        = 5'd1;
        tick();
        bus_if.alloc_wr_mem    = 1'b1;
        bus_if.alloc_store_dep = 2'd0;
        tick();
        set_cdb(1'b1, 2'd0, 32'd5);
        tick();
        bus_if.alloc_enable = 1'b0;
        bus_if.alloc_wr_mem = 1'b0;
        set_cdb(1'b0, '0, '0);
        bus_if.read_rob_tag = 2'd1;
        #1;
        check("t5_prod_ready", 32'(bus_if.head_ready), 1);
        check("t5_st1_value", bus_if.read_value, 5);
        bus_if.read_rob_tag = 2'd2;
        #1;
        check("t5_st2_value", bus_if.read_value, 5);
        tick();
        check("t5_st1_vready", 32'(bus_if.head_entry.value_ready), 1);
        check("t5_st1_wait_addr", 32'(bus_if.head_ready), 0);
        set_cdb(1'b1, 2'd1, 32'h40);
        tick();
        set_cdb(1'b0, '0, '0);
        #1;
        check("t5_st1_ready", 32'(bus_if.head_ready), 1);
        check("t5_st1_addr", bus_if.head_entry.dest_addr, 32'h40);

        // 6: pending-store queries (head=1: store@0x40 addr known, tag2 store addr unknown)
        bus_if.load_rob_tag = 2'd2;
        bus_if.load_address = 32'h40;
        #1;
        check("t6_alias", 32'(bus_if.pending_stores), 1);
        bus_if.load_address = 32'h80;
        #1;
`ifdef ROB_ADDR_DISAMBIG_EN
        check("t6_no_alias", 32'(bus_if.pending_stores), 0);
`else
        check("t6_no_alias", 32'(bus_if.pending_stores), 1);
`endif
        bus_if.load_rob_tag = 2'd1;
        #1;
        check("t6_empty_range", 32'(bus_if.pending_stores), 0);
        bus_if.load_rob_tag = 2'd3;
        #1;
        check("t6_unknown_addr", 32'(bus_if.pending_stores), 1);

        // Reset with entries in flight
        do_reset();
        #1;
        check("mid_rst_full", 32'(bus_if.full), 0);
        check("mid_rst_slot", 32'(bus_if.alloc_slot), 0);
        check("mid_rst_ready", 32'(bus_if.head_ready), 0);
        check("mid_rst_valid", 32'(bus_if.head_entry.valid), 0);
        check("mid_rst_pending", 32'(bus_if.pending_stores), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
